// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants, traceback FSM states and survivor-row helpers.
package viterbi_pkg;

  localparam int unsigned K      = 3;
  localparam int unsigned ST_W   = K - 1;
  localparam int unsigned NUM_ST = 1 << ST_W;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned ROW_W  = NUM_ST * ST_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_STEP,
    ST_EMIT
  } tb_state_e;

  // Entry s of a flattened survivor row: the predecessor state of state s.
  function automatic logic [ST_W-1:0] row_entry(input logic [ROW_W-1:0] row,
                                                input logic [ST_W-1:0]  s);
    return row[int'(s) * ST_W +: ST_W];
  endfunction

endpackage

// File: rtl/tb_bit_buf.sv
// DEPTH x 1 decoded-bit buffer: filled in reverse time order by the traceback,
// read in forward order by the emitter.
module tb_bit_buf
  import viterbi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_bit,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_bit
);

  logic [DEPTH-1:0] r_mem;

  // Store one decoded bit per traceback step; reset wipes the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_bit;
    end
  end

  assign o_rd_bit = r_mem[i_rd_addr];

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback reader: walks survivor pointers backwards from the winning
// end state, buffers one bit per step, then streams the bits out in time order.
module viterbi_traceback
  import viterbi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ST_W-1:0]   i_best_st,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [ROW_W-1:0]  i_rd_data,
  output logic              o_bit,
  output logic              o_bit_valid,
  input  logic              i_bit_ready,
  output logic              o_last,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned      LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

  tb_state_e         r_state;
  tb_state_e         w_state_nxt;
  logic [ST_W-1:0]   r_cur_st;
  logic [ADDR_W-1:0] r_t;
  logic [ADDR_W-1:0] r_idx;
  logic [LEN_W-1:0]  r_len;
  logic              r_done;
  logic              r_err;

  logic w_len_ok;
  logic w_accept;
  logic w_reject;
  logic w_wr_en;
  logic w_xfer;
  logic w_last;
  logic w_buf_bit;

  assign w_len_ok = (i_len != '0) && (i_len <= LEN_MAX);
  assign w_last   = ({1'b0, r_idx} == (r_len - LEN_W'(1)));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes; READ/STEP alternate, so one step costs two cycles.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b1;
    o_rd_en     = 1'b0;
    o_bit_valid = 1'b0;
    w_wr_en     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_xfer      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (w_len_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_READ;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_READ: begin
        o_rd_en     = 1'b1;
        w_state_nxt = ST_STEP;
      end
      ST_STEP: begin
        w_wr_en     = 1'b1;
        w_state_nxt = (r_t == '0) ? ST_EMIT : ST_READ;
      end
      ST_EMIT: begin
        o_bit_valid = 1'b1;
        if (i_bit_ready) begin
          w_xfer = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Traceback registers: current state, step/emit counters, done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_st <= '0;
      r_t      <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_xfer & w_last;
      r_err  <= w_reject;
      if (w_accept) begin
        r_cur_st <= i_best_st;
        r_t      <= ADDR_W'(i_len - LEN_W'(1));
        r_len    <= i_len;
        r_idx    <= '0;
      end
      if (r_state == ST_STEP) begin
        r_cur_st <= row_entry(i_rd_data, r_cur_st);
        if (r_t != '0) begin
          r_t <= r_t - ADDR_W'(1);
        end else begin
          r_idx <= '0;
        end
      end
      if (w_xfer && !w_last) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
    end
  end

  tb_bit_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_t),
    .i_wr_bit  (r_cur_st[ST_W-1]),
    .i_rd_addr (r_idx),
    .o_rd_bit  (w_buf_bit)
  );

  assign o_rd_addr = o_rd_en ? r_t : '0;
  assign o_bit     = o_bit_valid & w_buf_bit;
  assign o_last    = o_bit_valid & w_last;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: vector table plus hand-written
// stall, ignored-start, back-to-back and mid-frame reset sequences.
module tb_viterbi_traceback;
  import viterbi_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [ST_W-1:0]   i_best_st;
  logic [ADDR_W:0]   i_len;
  logic              o_busy;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [ROW_W-1:0]  rd_data;
  logic              o_bit;
  logic              o_bit_valid;
  logic              i_bit_ready;
  logic              o_last;
  logic              o_done;
  logic              o_err;

  logic [ROW_W-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  // Survivor memory model: registered read, data valid one cycle after o_rd_en.
  always @(posedge clk) begin
    if (o_rd_en) rd_data <= mem[o_rd_addr];
  end

  viterbi_traceback dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_best_st   (i_best_st),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (rd_data),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .i_bit_ready (i_bit_ready),
    .o_last      (o_last),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  typedef struct {
    logic [DEPTH*ROW_W-1:0] rows;
    logic [ST_W-1:0]        best;
    logic [ADDR_W:0]        len;
    logic [DEPTH-1:0]       exp_bits;  // bit t = decoded bit of step t
    logic                   exp_err;
  } vec_t;

  localparam logic [DEPTH*ROW_W-1:0] ENC_ROWS = 64'hFBCF_FDFF_BFDF_FBCF;

  vec_t vt [9];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rd_cnt, err_cnt, done_cnt, busy_cnt, tx_cnt;
  int first_valid_cyc, done_cyc, acc;
  int stall_left;
  bit seen_valid;
  bit stall_prev = 1'b0;
  logic prev_bit, prev_last;
  logic [1:0]        bit_q  [$];  // {last, bit}
  logic [ADDR_W-1:0] addr_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe/score on the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [1:0]        eb;
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (o_busy) busy_cnt++;
      if (o_err)  err_cnt++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_with_busy_low", o_busy, 0);
      end
      if (o_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) chk("unexpected_rd_en", o_rd_en, 0);
        else begin
          ea = addr_q.pop_front();
          chk("rd_addr", o_rd_addr, ea);
        end
      end
      if (stall_prev) begin
        chk("stall_valid_held", o_bit_valid, 1);
        chk("stall_bit_held", o_bit, prev_bit);
        chk("stall_last_held", o_last, prev_last);
      end
      stall_prev = 1'b0;
      if (o_bit_valid) begin
        chk("valid_implies_busy", o_busy, 1);
        if (!seen_valid) begin
          seen_valid = 1'b1;
          first_valid_cyc = cyc;
        end
        if (i_bit_ready) begin
          if (bit_q.size() == 0) chk("unexpected_bit_valid", o_bit_valid, 0);
          else begin
            eb = bit_q.pop_front();
            chk("bit_last", {o_last, o_bit}, eb);
          end
          tx_cnt++;
        end else begin
          stall_prev = 1'b1;
          prev_bit   = o_bit;
          prev_last  = o_last;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    rd_cnt = 0; err_cnt = 0; done_cnt = 0; busy_cnt = 0; tx_cnt = 0;
    seen_valid = 1'b0; first_valid_cyc = 0; done_cyc = 0;
  endtask

  task automatic load_rows(input logic [DEPTH*ROW_W-1:0] rows);
    for (int t = 0; t < DEPTH; t++) mem[t] = rows[t*ROW_W +: ROW_W];
  endtask

  task automatic push_expect(input logic [DEPTH-1:0] bits, input logic [ADDR_W:0] len);
    for (int t = int'(len) - 1; t >= 0; t--) addr_q.push_back(ADDR_W'(t));
    for (int i = 0; i < int'(len); i++) bit_q.push_back({(i == int'(len) - 1), bits[i]});
  endtask

  task automatic drive_start(input logic [ST_W-1:0] best, input logic [ADDR_W:0] len);
    i_start = 1'b1; i_best_st = best; i_len = len;
    acc = cyc + 1;
    cycle();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    for (int i = 0; i < limit && done_cnt < target; i++) cycle();
    chk("done_timeout", (done_cnt >= target), 1);
  endtask

  task automatic run_frame(input logic [ST_W-1:0] best, input logic [ADDR_W:0] len,
                           input logic [DEPTH-1:0] bits);
    clear_stats();
    push_expect(bits, len);
    drive_start(best, len);
    wait_done(1, 200);
    cycle();
    chk("first_valid_latency", first_valid_cyc - acc, 2*int'(len) + 1);
    chk("done_latency", done_cyc - acc, 3*int'(len) + 1);
    chk("done_pulses", done_cnt, 1);
    chk("transfers", tx_cnt, int'(len));
    chk("bits_left", bit_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
    chk("idle_after_frame", o_busy, 0);
  endtask

  task automatic run_err(input logic [ADDR_W:0] len);
    clear_stats();
    drive_start(2'b00, len);
    repeat (4) cycle();
    chk("err_pulses", err_cnt, 1);
    chk("err_no_rd_en", rd_cnt, 0);
    chk("err_busy_low", busy_cnt, 0);
  endtask

  initial begin
    vt[0] = '{rows: '0,        best: 2'b00, len: 4'd8,  exp_bits: 8'h00, exp_err: 1'b0};
    vt[1] = '{rows: ENC_ROWS,  best: 2'b01, len: 4'd8,  exp_bits: 8'h4D, exp_err: 1'b0};
    vt[2] = '{rows: ENC_ROWS,  best: 2'b11, len: 4'd4,  exp_bits: 8'h0D, exp_err: 1'b0};
    vt[3] = '{rows: '0,        best: 2'b00, len: 4'd0,  exp_bits: 8'h00, exp_err: 1'b1};
    vt[4] = '{rows: '0,        best: 2'b00, len: 4'd9,  exp_bits: 8'h00, exp_err: 1'b1};
    vt[5] = '{rows: '0,        best: 2'b10, len: 4'd1,  exp_bits: 8'h01, exp_err: 1'b0};
    vt[6] = '{rows: '0,        best: 2'b00, len: 4'd15, exp_bits: 8'h00, exp_err: 1'b1};
    vt[7] = '{rows: {8{8'hE4}}, best: 2'b10, len: 4'd5, exp_bits: 8'h1F, exp_err: 1'b0};
    vt[8] = '{rows: {8{8'h1B}}, best: 2'b01, len: 4'd6, exp_bits: 8'h15, exp_err: 1'b0};

    rst = 1'b1; i_start = 1'b0; i_best_st = '0; i_len = '0; i_bit_ready = 1'b1;
    load_rows('0);
    clear_stats();
    repeat (3) cycle();
    chk("reset_outputs", {o_busy, o_rd_en, o_rd_addr, o_bit, o_bit_valid, o_last, o_done, o_err}, 0);
    rst = 1'b0;
    cycle();

    // Vector table
    for (int v = 0; v < 9; v++) begin
      load_rows(vt[v].rows);
      if (vt[v].exp_err) run_err(vt[v].len);
      else run_frame(vt[v].best, vt[v].len, vt[v].exp_bits);
    end

    // Sink stall on the third bit
    load_rows(ENC_ROWS);
    clear_stats();
    push_expect(8'h4D, 4'd8);
    drive_start(2'b01, 4'd8);
    stall_left = 3;
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      cycle();
      if (o_bit_valid && tx_cnt == 2 && stall_left > 0) begin
        chk("stall_bit_value", o_bit, 1);
        i_bit_ready = 1'b0;
        stall_left--;
      end else begin
        i_bit_ready = 1'b1;
      end
    end
    i_bit_ready = 1'b1;
    chk("stall_done", done_cnt, 1);
    chk("stall_cycles_used", stall_left, 0);
    chk("stall_transfers", tx_cnt, 8);
    chk("stall_bits_left", bit_q.size(), 0);

    // Start pulses during READ/STEP are ignored
    cycle();
    clear_stats();
    push_expect(8'h4D, 4'd8);
    drive_start(2'b01, 4'd8);
    repeat (2) cycle();
    i_start = 1'b1; i_best_st = 2'b00; i_len = 4'd2;
    repeat (2) cycle();
    i_start = 1'b0;
    wait_done(1, 200);
    cycle();
    chk("busy_start_transfers", tx_cnt, 8);
    chk("busy_start_no_err", err_cnt, 0);
    chk("busy_start_bits_left", bit_q.size(), 0);
    chk("busy_start_addrs_left", addr_q.size(), 0);

    // Start accepted in the o_done cycle
    clear_stats();
    push_expect(8'h4D, 4'd8);
    drive_start(2'b01, 4'd8);
    for (int i = 0; i < 200 && !o_done; i++) cycle();
    chk("chain_done_seen", o_done, 1);
    push_expect(8'h0D, 4'd4);
    drive_start(2'b11, 4'd4);
    chk("chain_accepted", o_busy, 1);
    wait_done(2, 200);
    cycle();
    chk("chain_transfers", tx_cnt, 12);
    chk("chain_bits_left", bit_q.size(), 0);
    chk("chain_addrs_left", addr_q.size(), 0);

    // Reset during EMIT at idx=4
    clear_stats();
    push_expect(8'h4D, 4'd8);
    drive_start(2'b01, 4'd8);
    for (int i = 0; i < 200 && !(o_bit_valid && tx_cnt == 4); i++) cycle();
    chk("rst_at_idx4", tx_cnt, 4);
    rst = 1'b1;
    cycle();
    chk("rst_mid_emit_outputs",
        {o_busy, o_rd_en, o_rd_addr, o_bit, o_bit_valid, o_last, o_done, o_err}, 0);
    rst = 1'b0;
    bit_q.delete();
    addr_q.delete();
    clear_stats();
    repeat (3) cycle();
    chk("rst_no_resume", busy_cnt + done_cnt, 0);
    load_rows({8{8'h1B}});
    run_frame(2'b01, 4'd6, 8'h15);
    load_rows(ENC_ROWS);
    run_frame(2'b01, 4'd8, 8'h4D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
